scan_chain_sequencer: RTL
=========================

Name: scan_chain_sequencer

Overview:
- Sequences the shared TT02 scan chain that links every user design slot inside the user project wrapper.
- Each refresh round does four things in order:
  - captures the outputs of all designs into the chain;
  - shifts the chain end to end, injecting the 8 input bits for the selected design and extracting its 8 output bits;
  - pulses the latch strobe so each design's input latches load;
  - publishes the captured outputs and flags ready.
- The block is the only master of the chain pins. It runs from the caravel clock.

Parameters:
- NUM_DESIGNS, 250, number of 8-bit design slots in the chain; chain length TOTAL = NUM_DESIGNS*8.
- LATCH_CYCLES, 2, number of clk cycles scan_latch_en is held high (must be >= 1).

Ports:
- clk  input  1  system clock (caravel clock).
- reset_n  input  1  asynchronous active-low reset.
- run  input  1  1 = refresh rounds run back to back; 0 = stop after the current round.
- sel  input  9  index of the active design; values >= NUM_DESIGNS select nothing.
- io_in  input  8  input byte for the active design.
- io_out  output  8  output byte captured from the active design.
- ready  output  1  one-cycle pulse when io_out updates.
- scan_clk  output  1  chain shift clock.
- scan_data_out  output  1  serial data into the chain head (slot 0 side).
- scan_data_in  input  1  serial data from the chain tail.
- scan_select  output  1  1 = chain flops capture design outputs on the scan_clk rising edge; 0 = shift.
- scan_latch_en  output  1  high = design input latches load from the chain.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; all outputs 0, including io_out, ready, scan_clk, scan_data_out, scan_select and scan_latch_en; bit counter 0.
- Reset asserted mid-round aborts the round immediately; no partial io_out update.
- States: IDLE, CAPTURE, SHIFT, LATCH, DONE.
- IDLE:
  - run=1 -> CAPTURE on the next cycle.
  - sel and io_in are registered into sel_q and in_q on that transition.
  - Changes to sel or io_in during a round have no effect on that round.
- CAPTURE, 2 cycles:
  - cycle 0: scan_select=1, scan_clk=0.
  - cycle 1: scan_select=1, scan_clk=1 (rising edge captures).
  - Then -> SHIFT with k=0.
- SHIFT, 2 cycles per bit, k = 0 .. TOTAL-1, scan_select=0:
  - phase 0: scan_clk=0; scan_data_out is valid; scan_data_in is sampled at the end of this phase.
  - phase 1: scan_clk=1.
  - Position mapping: p = TOTAL-1-k. If p lies in [sel_q*8, sel_q*8+7], let b = p - sel_q*8:
    - scan_data_out = in_q[b];
    - the scan_data_in sample goes to out_q[b].
  - Otherwise scan_data_out=0 and the sample is discarded.
  - After k=TOTAL-1, phase 1 -> LATCH.
  - The counter is wide enough for TOTAL with no wrap.
- LATCH:
  - 1 settle cycle with scan_clk=0 and scan_latch_en=0.
  - Then LATCH_CYCLES cycles with scan_latch_en=1.
  - Then -> DONE.
- DONE, 1 cycle:
  - io_out <= out_q if sel_q < NUM_DESIGNS; otherwise io_out is unchanged.
  - ready=1 for this cycle only.
  - Next state: run=1 -> CAPTURE (sel and io_in resampled); run=0 -> IDLE.
- Round length = 2 + 2*TOTAL + 1 + LATCH_CYCLES + 1 cycles.
- run falling mid-round: the round completes normally and ready still pulses.
- sel >= NUM_DESIGNS: the chain is shifted with zeros everywhere, the latch strobe is still issued, io_out holds its value, ready still pulses.
- io_out, scan_clk, scan_data_out, scan_select and scan_latch_en are driven directly from flops (glitch-free).

Optional Feature:
- SCAN_SLOW_CLK_EN defined:
  - Adds ports set_clk_div (input, 1) and slow_clk (output, 1).
  - Adds a 4-bit register div. Reset values: div=0, slow_clk=0.
  - At each round start where set_clk_div=1: div <= io_in[3:0].
  - slow_clk toggles in the DONE cycle of every (div+1)-th completed round; aborted rounds do not count.
- Undefined: the ports, register and round counter are absent; there is no other difference.

Test Plan (NUM_DESIGNS=4, LATCH_CYCLES=2, round length = 70 cycles):
- Release reset, run=1, sel=2, io_in=0xA5; the chain model's slot 2 outputs 0x3C -> ready pulses at cycle 69 of round 1; io_out=0x3C; the model's slot 2 input latch = 0xA5; all other slots latch 0x00.
- Check scan waveform timing for one round:
  - scan_select high only during the 2 CAPTURE cycles;
  - exactly 32 scan_clk rising edges in SHIFT;
  - scan_latch_en high for exactly 2 cycles, after the settle cycle.
- sel=7 (invalid), io_out previously 0x3C -> full round runs, all slots latch 0x00, ready pulses, io_out stays 0x3C.
- run dropped at SHIFT bit 10 -> round completes, ready pulses, state returns to IDLE, no further scan_clk edges.
- Change sel from 2 to 1 at cycle 20 of a round -> that round still serves slot 2; the next round serves slot 1.
- reset_n pulsed low at SHIFT bit 5 -> all outputs 0 immediately; after release with run=1, a fresh full round of 70 cycles runs.
- SCAN_SLOW_CLK_EN defined, set_clk_div=1, io_in=0x02 -> slow_clk toggles every 3rd round: ready pulse 3 coincides with the first toggle, ready pulse 6 with the second.

Source files
------------

// File: rtl/scan_chain_sequencer.sv
// Refresh sequencer for the shared TT02 user-design scan chain: capture, shift, latch, publish.
// Optional `define SCAN_SLOW_CLK_EN adds set_clk_div/slow_clk, a clock that toggles every (div+1) rounds.
module scan_chain_sequencer #(
    parameter int NUM_DESIGNS  = 250,
    parameter int LATCH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic [8:0] sel,
    input  logic [7:0] io_in,
    output logic [7:0] io_out,
    output logic       ready,
    output logic       scan_clk,
    output logic       scan_data_out,
    input  logic       scan_data_in,
    output logic       scan_select,
    output logic       scan_latch_en
`ifdef SCAN_SLOW_CLK_EN
    ,
    input  logic       set_clk_div,
    output logic       slow_clk
`endif
);

    localparam int TOTAL = NUM_DESIGNS * 8;
    localparam int KW    = $clog2(TOTAL + 1);
    localparam int LW    = $clog2(LATCH_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SHIFT   = 3'd2,
        LATCH   = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Shift step k touches chain position TOTAL-1-k; returns {hit, bit index} for slot s.
    function automatic logic [3:0] slot_bit(input logic [KW-1:0] k, input logic [8:0] s);
        logic [31:0] pos;
        pos = 32'(TOTAL - 1) - 32'(k);
        return {(pos[31:3] == {20'd0, s}), pos[2:0]};
    endfunction

    state_t          state_r, state_s;
    logic            phase_r, phase_s;
    logic [KW-1:0]   k_r, k_s;
    logic [LW-1:0]   lcnt_r, lcnt_s;
    logic            load_s;
    logic [8:0]      sel_q_r;
    logic [7:0]      in_q_r;
    logic [7:0]      out_q_r;
    logic [3:0]      drive_s;
    logic [3:0]      sample_s;
    logic            sdo_s;
    logic            sel_ok_s;

    // Next-state sequencing of the round.
    always_comb begin
        state_s = state_r;
        phase_s = phase_r;
        k_s     = k_r;
        lcnt_s  = lcnt_r;
        load_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (run) begin
                    state_s = CAPTURE;
                    phase_s = 1'b0;
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            CAPTURE: begin
                if (!phase_r) begin
                    phase_s = 1'b1;
                end else begin
                    state_s = SHIFT;
                    phase_s = 1'b0;
                    k_s     = {KW{1'b0}};
                end
            end
            SHIFT: begin
                if (!phase_r) begin
                    phase_s = 1'b1;
                end else if (k_r == KW'(TOTAL - 1)) begin
                    state_s = LATCH;
                    phase_s = 1'b0;
                    lcnt_s  = {LW{1'b0}};
                end else begin
                    k_s     = k_r + KW'(1);
                    phase_s = 1'b0;
                end
            end
            LATCH: begin
                if (lcnt_r == LW'(LATCH_CYCLES)) begin
                    state_s = DONE;
                end else begin
                    lcnt_s = lcnt_r + LW'(1);
                end
            end
            DONE: begin
                if (run) begin
                    state_s = CAPTURE;
                    phase_s = 1'b0;
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                phase_s = 1'b0;
            end
        endcase
    end

    // Chain-side decode: bit driven next cycle and bit sampled this cycle.
    always_comb begin
        drive_s  = slot_bit(k_s, sel_q_r);
        sample_s = slot_bit(k_r, sel_q_r);
        sel_ok_s = ({23'd0, sel_q_r} < 32'(NUM_DESIGNS));
        if ((state_s == SHIFT) && drive_s[3]) begin
            sdo_s = in_q_r[drive_s[2:0]];
        end else begin
            sdo_s = 1'b0;
        end
    end

    // Sequencer state and per-round operand registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            phase_r <= 1'b0;
            k_r     <= {KW{1'b0}};
            lcnt_r  <= {LW{1'b0}};
            sel_q_r <= 9'd0;
            in_q_r  <= 8'd0;
            out_q_r <= 8'd0;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
            k_r     <= k_s;
            lcnt_r  <= lcnt_s;
            if (load_s) begin
                sel_q_r <= sel;
                in_q_r  <= io_in;
            end
            if ((state_r == SHIFT) && !phase_r && sample_s[3]) begin
                out_q_r[sample_s[2:0]] <= scan_data_in;
            end
        end
    end

    // Chain pins and host outputs come straight from flops, decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            io_out        <= 8'd0;
            ready         <= 1'b0;
            scan_clk      <= 1'b0;
            scan_data_out <= 1'b0;
            scan_select   <= 1'b0;
            scan_latch_en <= 1'b0;
        end else begin
            scan_select   <= (state_s == CAPTURE);
            scan_clk      <= ((state_s == CAPTURE) || (state_s == SHIFT)) && phase_s;
            scan_data_out <= sdo_s;
            scan_latch_en <= (state_s == LATCH) && (lcnt_s != {LW{1'b0}});
            ready         <= (state_s == DONE);
            if ((state_s == DONE) && sel_ok_s) begin
                io_out <= out_q_r;
            end
        end
    end

`ifdef SCAN_SLOW_CLK_EN
    logic [3:0] div_r;
    logic [3:0] rcnt_r;

    // Divided clock: toggles on the DONE cycle of every (div+1)-th completed round.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_r    <= 4'd0;
            rcnt_r   <= 4'd0;
            slow_clk <= 1'b0;
        end else begin
            if (load_s && set_clk_div) begin
                div_r <= io_in[3:0];
            end
            if (state_s == DONE) begin
                if (rcnt_r >= div_r) begin
                    rcnt_r   <= 4'd0;
                    slow_clk <= ~slow_clk;
                end else begin
                    rcnt_r <= rcnt_r + 4'd1;
                end
            end
        end
    end
`endif

endmodule
